// File: rtl/ace_keyboard_if.sv
// PS/2 event and CPU keyboard-port bundle for ace_keyboard.
// Master drives key events and row select; slave returns columns/reset.
interface ace_keyboard_if;
  logic [10:0] ps2_key;
  logic [7:0]  kbd_rows;
  logic [4:0]  kbd_columns;
  logic        kbd_reset;

  modport master (
    output ps2_key,
    output kbd_rows,
    input  kbd_columns,
    input  kbd_reset
  );

  modport slave (
    input  ps2_key,
    input  kbd_rows,
    output kbd_columns,
    output kbd_reset
  );
endinterface

// File: rtl/ace_keyboard.sv
// PS/2 set-2 events to Jupiter Ace 8x5 keyboard matrix,
// plus Ctrl+Alt+Del stretched active-low reset request.
module ace_keyboard #(
  parameter logic [7:0] RESET_STRETCH = 8'd255
) (
  input  logic          clkcpu,
  input  logic          reset,
  ace_keyboard_if.slave bus
);

  // Returns {hit, row, col}; octal literal digits are row,col.
  function automatic logic [6:0] map_plain(
    input logic [7:0] sc
  );
    logic [6:0] r;
    r = {1'b1, 6'o00};
    unique case (sc)
      8'h12, 8'h59: r[5:0] = 6'o00;
      8'h14: r[5:0] = 6'o01;
      8'h1A: r[5:0] = 6'o02;
      8'h22: r[5:0] = 6'o03;
      8'h21: r[5:0] = 6'o04;
      8'h1C: r[5:0] = 6'o10;
      8'h1B: r[5:0] = 6'o11;
      8'h23: r[5:0] = 6'o12;
      8'h2B: r[5:0] = 6'o13;
      8'h34: r[5:0] = 6'o14;
      8'h15: r[5:0] = 6'o20;
      8'h1D: r[5:0] = 6'o21;
      8'h24: r[5:0] = 6'o22;
      8'h2D: r[5:0] = 6'o23;
      8'h2C: r[5:0] = 6'o24;
      8'h16: r[5:0] = 6'o30;
      8'h1E: r[5:0] = 6'o31;
      8'h26: r[5:0] = 6'o32;
      8'h25: r[5:0] = 6'o33;
      8'h2E: r[5:0] = 6'o34;
      8'h45: r[5:0] = 6'o40;
      8'h46: r[5:0] = 6'o41;
      8'h3E: r[5:0] = 6'o42;
      8'h3D: r[5:0] = 6'o43;
      8'h36: r[5:0] = 6'o44;
      8'h4D: r[5:0] = 6'o50;
      8'h44: r[5:0] = 6'o51;
      8'h43: r[5:0] = 6'o52;
      8'h3C: r[5:0] = 6'o53;
      8'h35: r[5:0] = 6'o54;
      8'h5A: r[5:0] = 6'o60;
      8'h4B: r[5:0] = 6'o61;
      8'h42: r[5:0] = 6'o62;
      8'h3B: r[5:0] = 6'o63;
      8'h33: r[5:0] = 6'o64;
      8'h29: r[5:0] = 6'o70;
      8'h3A: r[5:0] = 6'o71;
      8'h31: r[5:0] = 6'o72;
      8'h32: r[5:0] = 6'o73;
      8'h2A: r[5:0] = 6'o74;
      default: r = 7'd0;
    endcase
    return r;
  endfunction

  logic        armed_q, tgl_q, evt_q;
  logic [9:0]  key_q;
  logic [7:0][4:0] m_q, m_d;
  logic        bs_q, lf_q, dn_q, up_q, rt_q;
  logic        bs_d, lf_d, dn_d, up_d, rt_d;
  logic        ctrl_q, alt_q, del_q;
  logic        ctrl_d, alt_d, del_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  cols_q, cols_d;
  logic        krst_q, krst_d;

  logic        mk, ext, hit, combo;
  logic [7:0]  sc;
  logic [5:0]  rc;
  logic [7:0][4:0] eff;
  logic [4:0]  sel;

  assign mk  = key_q[9];
  assign ext = key_q[8];
  assign sc  = key_q[7:0];

  always_comb begin
    m_d    = m_q;
    bs_d   = bs_q;
    lf_d   = lf_q;
    dn_d   = dn_q;
    up_d   = up_q;
    rt_d   = rt_q;
    ctrl_d = ctrl_q;
    alt_d  = alt_q;
    del_d  = del_q;
    hit    = 1'b0;
    rc     = 6'o00;
    if (evt_q) begin
      if (!ext) begin
        {hit, rc} = map_plain(sc);
        if (sc == 8'h66) bs_d = mk;
      end else begin
        unique case (sc)
          8'h14: {hit, rc} = {1'b1, 6'o01};
          8'h5A: {hit, rc} = {1'b1, 6'o60};
          8'h6B: lf_d  = mk;
          8'h72: dn_d  = mk;
          8'h75: up_d  = mk;
          8'h74: rt_d  = mk;
          8'h71: del_d = mk;
          default: hit = 1'b0;
        endcase
      end
      if (sc == 8'h14) ctrl_d = mk;
      if (sc == 8'h11) alt_d  = mk;
      if (hit) m_d[rc[5:3]][rc[2:0]] = mk;
    end
  end

  // Composites add SHIFT and their target without touching physical bits.
  always_comb begin
    eff       = m_q;
    eff[0][0] = m_q[0][0] | bs_q | lf_q | dn_q | up_q | rt_q;
    eff[4][0] = m_q[4][0] | bs_q;
    eff[3][4] = m_q[3][4] | lf_q;
    eff[4][4] = m_q[4][4] | dn_q;
    eff[4][3] = m_q[4][3] | up_q;
    eff[4][2] = m_q[4][2] | rt_q;
  end

  always_comb begin
    sel = 5'd0;
    for (int r = 0; r < 8; r++) begin
      if (!bus.kbd_rows[r]) sel = sel | eff[r];
    end
    cols_d = ~sel;
  end

  assign combo  = ctrl_q & alt_q & del_q;
  assign cnt_d  = combo ? RESET_STRETCH :
                  (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
  assign krst_d = ~(combo | (cnt_q != 8'd0));

  // First edge after reset only adopts the current toggle.
  always_ff @(posedge clkcpu or posedge reset) begin
    if (reset) begin
      armed_q <= 1'b0;
      tgl_q   <= 1'b0;
      evt_q   <= 1'b0;
      key_q   <= 10'd0;
      m_q     <= '0;
      bs_q    <= 1'b0;
      lf_q    <= 1'b0;
      dn_q    <= 1'b0;
      up_q    <= 1'b0;
      rt_q    <= 1'b0;
      ctrl_q  <= 1'b0;
      alt_q   <= 1'b0;
      del_q   <= 1'b0;
      cnt_q   <= 8'd0;
      cols_q  <= 5'b11111;
      krst_q  <= 1'b1;
    end else begin
      armed_q <= 1'b1;
      tgl_q   <= bus.ps2_key[10];
      evt_q   <= armed_q & (bus.ps2_key[10] ^ tgl_q);
      key_q   <= bus.ps2_key[9:0];
      m_q     <= m_d;
      bs_q    <= bs_d;
      lf_q    <= lf_d;
      dn_q    <= dn_d;
      up_q    <= up_d;
      rt_q    <= rt_d;
      ctrl_q  <= ctrl_d;
      alt_q   <= alt_d;
      del_q   <= del_d;
      cnt_q   <= cnt_d;
      cols_q  <= cols_d;
      krst_q  <= krst_d;
    end
  end

  assign bus.kbd_columns = cols_q;
  assign bus.kbd_reset   = krst_q;

endmodule
